// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver.
// Frame-shadowed hex value, per-slot blank interval, registered pins.
module seven_seg_scan #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_blank,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;

  localparam logic [TW-1:0] TMAX = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] TBLK = TW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

  logic [TW-1:0]     tick_cnt;
  logic [IW-1:0]     digit_idx;
  logic [VW-1:0]     pend_val;
  logic [DIGITS-1:0] pend_dp;
  logic              pend_v;
  logic [VW-1:0]     disp_val;
  logic [DIGITS-1:0] disp_dp;

  logic slot_end;
  logic frame_wrap;

  assign slot_end   = (tick_cnt == TMAX);
  assign frame_wrap = slot_end && (digit_idx == IMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      tick_cnt  <= '0;
      digit_idx <= frame_wrap ? '0 : digit_idx + 1'b1;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
    end
  end

  // A load landing on the wrap cycle bypasses the pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else if (load && frame_wrap) begin
      disp_val <= value;
      disp_dp  <= dp_in;
      pend_v   <= 1'b0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend_v   <= 1'b1;
    end else if (frame_wrap && pend_v) begin
      disp_val <= pend_val;
      disp_dp  <= pend_dp;
      pend_v   <= 1'b0;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  logic [DIGITS-1:0] zero_up;
  logic [DIGITS-1:0] sel;
  logic [3:0]        nib;
  logic              cur_dp;
  logic              cur_on;
  logic              lit;

  // zero_up[k]: nibble k and every higher nibble are zero
  always_comb begin
    zero_up = '0;
    zero_up[DIGITS-1] = (disp_val[VW-1 -: 4] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      zero_up[k] = (disp_val[k*4 +: 4] == 4'h0) && zero_up[k+1];
    end
  end

  always_comb begin
    sel    = '0;
    nib    = 4'h0;
    cur_dp = 1'b0;
    cur_on = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx == IW'(k)) begin
        sel[k] = 1'b1;
        nib    = disp_val[k*4 +: 4];
        cur_dp = disp_dp[k];
        cur_on = digit_en[k] && !(lz_blank && (k != 0) && zero_up[k]);
      end
    end
    lit = cur_on && (tick_cnt >= TBLK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= '1;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= lit ? ~sel : '1;
      seg_n      <= lit ? ~hex7(nib) : 7'h7F;
      dp_n       <= lit ? ~cur_dp : 1'b1;
      frame_done <= frame_wrap;
    end
  end

endmodule
